sd_dat_controller_mb: RTL and testbench
=======================================

Name: sd_dat_controller_mb

Overview:
- Second-generation SD data-path sequencer. It sits between the wishbone host registers, the data FIFO controller and the serial physical layer.
- Runs a transfer of 1..2^BLKCNT_W-1 blocks, read or write, with per-block ack handshake, automatic CRC retry, a per-state timeout watchdog and host abort.
- All outputs are registered. Errors are reported with a sticky code.

Parameters:
- BLKCNT_W, 8: width of block count and remaining-blocks counter.
- TIMEOUT_W, 16: width of timeout load value and watchdog counter.
- MAX_RETRY, 2: retransmissions allowed per block after a CRC failure (0 = no retry).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  host request; sampled only in IDLE.
- write_read  in  1  1=write, 0=read; latched at start.
- multiple  in  1  multi-block mode; latched at start.
- block_count  in  BLKCNT_W  blocks to move; latched at start.
- timeout_val  in  TIMEOUT_W  watchdog load value; 0 disables the watchdog; latched at start.
- abort  in  1  host abort.
- serial_ready  in  1  phys layer ready for setup.
- fifo_okay  in  1  FIFO has data/space for one block.
- block_done  in  1  phys finished one block (1-cycle pulse).
- crc_ok  in  1  CRC result, valid with block_done.
- ack_in  in  1  phys acknowledges ack_out.
- strobe_out  out  1  block transfer enable to phys.
- ack_out  out  1  block acknowledge to phys.
- write_read_phys  out  1  latched direction.
- multiple_phys  out  1  latched mode.
- blocks_left  out  BLKCNT_W  remaining blocks including the current one.
- busy  out  1  high in every state except IDLE.
- transfer_complete  out  1  1-cycle pulse on successful end.
- error  out  1  sticky error flag.
- error_code  out  2  00 none, 01 timeout, 10 CRC retries exhausted, 11 abort.

Behaviour:
- Reset (synchronous, any state, mid-transfer included):
  - State goes to IDLE.
  - All outputs go to 0, error_code to 00; retry and watchdog counters cleared.
- States: IDLE, SETUP, CHECK_FIFO, TRANSMIT, ACK, DONE, ERROR.
- IDLE:
  - On start=1: latch write_read, multiple and timeout_val.
  - blocks_left loads block_count, forced to 1 when multiple=0 or block_count=0.
  - Clear error and error_code, retry=0, go to SETUP. busy rises the next cycle.
- SETUP: wait for serial_ready=1, then go to CHECK_FIFO.
- CHECK_FIFO: wait for fifo_okay=1, then go to TRANSMIT.
- TRANSMIT:
  - strobe_out=1 for the whole state.
  - On block_done with crc_ok=1: go to ACK.
  - On block_done with crc_ok=0 and retry<MAX_RETRY: retry++, go to CHECK_FIFO.
  - Otherwise (retries exhausted): go to ERROR with code 10.
- ACK:
  - ack_out=1; wait for ack_in=1, then retry=0.
  - If blocks_left==1: go to DONE; otherwise blocks_left-- and go to CHECK_FIFO.
- DONE:
  - blocks_left=0; transfer_complete=1 for exactly one cycle; go to IDLE.
- ERROR:
  - Set error=1 and error_code; strobe_out and ack_out go to 0 on entry.
  - One cycle later go to IDLE. error and error_code hold until the next accepted start.
- Watchdog:
  - Reloads with timeout_val on every entry into SETUP, CHECK_FIFO, TRANSMIT and ACK, including re-entry on retry or next block.
  - Decrements each cycle spent in the state. If it reaches 0 before the exit condition, go to ERROR with code 01.
  - Inactive when timeout_val=0.
- Priority when events coincide in one cycle:
  - abort (non-IDLE states) > watchdog expiry > normal transition.
  - abort in IDLE, DONE or ERROR is ignored.
- Outputs write_read_phys and multiple_phys hold their latched values from start until the next start.
- Latency: start to busy=1 is 1 cycle. The final ack_in to transfer_complete pulse is 2 cycles (through DONE).
- start while busy is ignored.

Test Plan:
- Single read: start, write_read=0, multiple=0, block_count=5, all handshakes immediate -> blocks_left=1, one strobe window, one ack_out, transfer_complete pulse, error=0.
- Multi write: block_count=3, multiple=1 -> three TRANSMIT/ACK pairs, blocks_left 3→2→1→0, a single transfer_complete pulse at the end.
- CRC retry, MAX_RETRY=2: first two block_done with crc_ok=0, third with crc_ok=1 -> three strobe windows, then ACK, then completion with error=0. A further case with three failures -> error=1, code 10, no transfer_complete.
- Timeout: timeout_val=4, fifo_okay held 0 -> ERROR entered after 4 cycles in CHECK_FIFO, code 01, busy falls the following cycle. With timeout_val=0 the controller waits indefinitely.
- Abort: abort=1 in the same cycle as block_done/crc_ok=1 in TRANSMIT -> ERROR with code 11, no ACK.
- Reset mid-ACK: all outputs return to 0, state IDLE. A new start afterwards runs to completion normally.

Source files
------------

// File: rtl/sd_dat_controller_mb_if.sv
// Host/FIFO/phys-facing signal bundle of the SD data-path sequencer.
interface sd_dat_controller_mb_if #(
    parameter int unsigned BLKCNT_W  = 8,
    parameter int unsigned TIMEOUT_W = 16
);
    logic                 start;
    logic                 write_read;
    logic                 multiple;
    logic [BLKCNT_W-1:0]  block_count;
    logic [TIMEOUT_W-1:0] timeout_val;
    logic                 abort;
    logic                 serial_ready;
    logic                 fifo_okay;
    logic                 block_done;
    logic                 crc_ok;
    logic                 ack_in;
    logic                 strobe_out;
    logic                 ack_out;
    logic                 write_read_phys;
    logic                 multiple_phys;
    logic [BLKCNT_W-1:0]  blocks_left;
    logic                 busy;
    logic                 transfer_complete;
    logic                 error;
    logic [1:0]           error_code;

    modport master (
        output start, write_read, multiple, block_count, timeout_val, abort,
               serial_ready, fifo_okay, block_done, crc_ok, ack_in,
        input  strobe_out, ack_out, write_read_phys, multiple_phys, blocks_left,
               busy, transfer_complete, error, error_code
    );

    modport slave (
        input  start, write_read, multiple, block_count, timeout_val, abort,
               serial_ready, fifo_okay, block_done, crc_ok, ack_in,
        output strobe_out, ack_out, write_read_phys, multiple_phys, blocks_left,
               busy, transfer_complete, error, error_code
    );
endinterface

// File: rtl/sd_dat_controller_mb.sv
// SD data-path sequencer: multi-block read/write with per-block ack, CRC retry,
// per-state watchdog, host abort and a sticky error code.
module sd_dat_controller_mb #(
    parameter int unsigned BLKCNT_W  = 8,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic                   clock,
    input logic                   reset,
    sd_dat_controller_mb_if.slave bus
);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_CRC     = 2'b10;
    localparam logic [1:0] CODE_ABORT   = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, CHECK_FIFO, TRANSMIT, ACK, DONE, ERROR} state_t;

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] wd, wd_n, tmo, tmo_n;
    logic [RETRY_W-1:0]   retry, retry_n;
    logic [BLKCNT_W-1:0]  left, left_n;
    logic                 wr, wr_n, mult, mult_n, err, err_n, tc_n;
    logic [1:0]           code, code_n;
    logic                 strobe, ack, busy, tc;
    logic                 go, active, expire;

    // Next-state and next-register values
    always_comb begin
        state_n = state;
        wd_n    = wd;
        tmo_n   = tmo;
        retry_n = retry;
        left_n  = left;
        wr_n    = wr;
        mult_n  = mult;
        err_n   = err;
        code_n  = code;
        tc_n    = 1'b0;
        go      = 1'b0;
        active  = (state inside {SETUP, CHECK_FIFO, TRANSMIT, ACK});
        expire  = (tmo != '0) && (wd == TIMEOUT_W'(1));

        case (state)
            IDLE: if (bus.start) begin
                go      = 1'b1;
                wr_n    = bus.write_read;
                mult_n  = bus.multiple;
                tmo_n   = bus.timeout_val;
                left_n  = (bus.multiple && bus.block_count != '0) ? bus.block_count : BLKCNT_W'(1);
                err_n   = 1'b0;
                code_n  = CODE_NONE;
                retry_n = '0;
                state_n = SETUP;
            end
            SETUP: if (bus.serial_ready) begin
                go      = 1'b1;
                state_n = CHECK_FIFO;
            end
            CHECK_FIFO: if (bus.fifo_okay) begin
                go      = 1'b1;
                state_n = TRANSMIT;
            end
            TRANSMIT: if (bus.block_done) begin
                go = 1'b1;
                if (bus.crc_ok) begin
                    state_n = ACK;
                end else if (retry < RETRY_W'(MAX_RETRY)) begin
                    retry_n = retry + RETRY_W'(1);
                    state_n = CHECK_FIFO;
                end else begin
                    err_n   = 1'b1;
                    code_n  = CODE_CRC;
                    state_n = ERROR;
                end
            end
            ACK: if (bus.ack_in) begin
                go      = 1'b1;
                retry_n = '0;
                if (left == BLKCNT_W'(1)) begin
                    state_n = DONE;
                end else begin
                    left_n  = left - BLKCNT_W'(1);
                    state_n = CHECK_FIFO;
                end
            end
            DONE: begin
                left_n  = '0;
                tc_n    = 1'b1;
                state_n = IDLE;
            end
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Abort beats watchdog expiry, which beats any normal transition
        if (active && (bus.abort || expire)) begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = bus.abort ? CODE_ABORT : CODE_TIMEOUT;
            retry_n = retry;
            left_n  = left;
        end else if (go) begin
            wd_n = tmo_n;
        end else if (active && tmo != '0) begin
            wd_n = wd - TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            wd     <= '0;
            tmo    <= '0;
            retry  <= '0;
            left   <= '0;
            wr     <= 1'b0;
            mult   <= 1'b0;
            err    <= 1'b0;
            code   <= CODE_NONE;
            strobe <= 1'b0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            wd     <= wd_n;
            tmo    <= tmo_n;
            retry  <= retry_n;
            left   <= left_n;
            wr     <= wr_n;
            mult   <= mult_n;
            err    <= err_n;
            code   <= code_n;
            strobe <= (state_n == TRANSMIT);
            ack    <= (state_n == ACK);
            busy   <= (state_n != IDLE);
            tc     <= tc_n;
        end
    end

    assign bus.strobe_out        = strobe;
    assign bus.ack_out           = ack;
    assign bus.write_read_phys   = wr;
    assign bus.multiple_phys     = mult;
    assign bus.blocks_left       = left;
    assign bus.busy              = busy;
    assign bus.transfer_complete = tc;
    assign bus.error             = err;
    assign bus.error_code        = code;
endmodule

// File: tb/tb_sd_dat_controller_mb.sv
// Bench for sd_dat_controller_mb: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a phase/elapsed-time model.
`timescale 1ns/1ps
module tb_sd_dat_controller_mb;
    localparam int unsigned BLKCNT_W  = 8;
    localparam int unsigned TIMEOUT_W = 16;
    localparam int unsigned MAX_RETRY = 2;
    localparam int P_IDLE = 0, P_SETUP = 1, P_FIFO = 2, P_XMIT = 3, P_ACK = 4, P_DONE = 5, P_ERR = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    sd_dat_controller_mb_if #(.BLKCNT_W(BLKCNT_W), .TIMEOUT_W(TIMEOUT_W)) bus ();

    sd_dat_controller_mb #(.BLKCNT_W(BLKCNT_W), .TIMEOUT_W(TIMEOUT_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles elapsed in it; outputs follow the phase.
    int m_phase = P_IDLE, m_elapsed = 0, m_tmo = 0, m_left = 0, m_tries = 0, m_code = 0;
    bit m_wr = 0, m_mult = 0, m_err = 0, m_tc = 0;

    task automatic m_fail(input int c);
        m_phase = P_ERR; m_err = 1'b1; m_code = c;
    endtask

    task automatic m_move(input int p);
        m_phase = p; m_elapsed = 0;
    endtask

    always @(posedge clock) begin
        m_tc = 1'b0;
        if (reset) begin
            m_phase = P_IDLE; m_elapsed = 0; m_tmo = 0; m_left = 0; m_tries = 0;
            m_code = 0; m_wr = 1'b0; m_mult = 1'b0; m_err = 1'b0;
        end else if (m_phase == P_IDLE) begin
            if (bus.start) begin
                m_wr = bus.write_read; m_mult = bus.multiple; m_tmo = int'(bus.timeout_val);
                m_left = (bus.multiple && bus.block_count != 0) ? int'(bus.block_count) : 1;
                m_err = 1'b0; m_code = 0; m_tries = 0;
                m_move(P_SETUP);
            end
        end else if (m_phase == P_DONE) begin
            m_left = 0; m_tc = 1'b1; m_phase = P_IDLE;
        end else if (m_phase == P_ERR) begin
            m_phase = P_IDLE;
        end else if (bus.abort) begin
            m_fail(3);
        end else if (m_tmo != 0 && m_elapsed + 1 >= m_tmo) begin
            m_fail(1);
        end else if (m_phase == P_SETUP && bus.serial_ready) begin
            m_move(P_FIFO);
        end else if (m_phase == P_FIFO && bus.fifo_okay) begin
            m_move(P_XMIT);
        end else if (m_phase == P_XMIT && bus.block_done) begin
            if (bus.crc_ok) m_move(P_ACK);
            else if (m_tries < int'(MAX_RETRY)) begin m_tries++; m_move(P_FIFO); end
            else m_fail(2);
        end else if (m_phase == P_ACK && bus.ack_in) begin
            m_tries = 0;
            if (m_left == 1) m_move(P_DONE);
            else begin m_left--; m_move(P_FIFO); end
        end else begin
            m_elapsed++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_strobe_out",  32'(bus.strobe_out),        32'(m_phase == P_XMIT));
            check("cmp_ack_out",     32'(bus.ack_out),           32'(m_phase == P_ACK));
            check("cmp_busy",        32'(bus.busy),              32'(m_phase != P_IDLE));
            check("cmp_complete",    32'(bus.transfer_complete), 32'(m_tc));
            check("cmp_wr_phys",     32'(bus.write_read_phys),   32'(m_wr));
            check("cmp_mult_phys",   32'(bus.multiple_phys),     32'(m_mult));
            check("cmp_blocks_left", 32'(bus.blocks_left),       32'(m_left));
            check("cmp_error",       32'(bus.error),             32'(m_err));
            check("cmp_error_code",  32'(bus.error_code),        32'(m_code));
        end
    end

    task automatic idle_inputs();
        bus.start = 1'b0; bus.write_read = 1'b0; bus.multiple = 1'b0; bus.block_count = '0;
        bus.timeout_val = '0; bus.abort = 1'b0; bus.serial_ready = 1'b0; bus.fifo_okay = 1'b0;
        bus.block_done = 1'b0; bus.crc_ok = 1'b0; bus.ack_in = 1'b0;
    endtask

    int r_strobes, r_acks, r_tc, r_busy_cyc;
    int r_left[8];

    // Starts a transfer and plays an immediate phys/FIFO responder; call at a negedge.
    task automatic run_xfer(input bit wr, input bit mult, input int bc, input int tmo, input int nfail,
                            input bit fifo_en, input bit ack_en, input bit abort_on_done,
                            input bit expect_end, input int max_cyc, input string tag);
        bit seen_busy = 1'b0, prev_strobe = 1'b0, prev_ack = 1'b0, ended = 1'b0;
        r_strobes = 0; r_acks = 0; r_tc = 0; r_busy_cyc = 0;
        bus.start = 1'b1; bus.write_read = wr; bus.multiple = mult;
        bus.block_count = BLKCNT_W'(bc); bus.timeout_val = TIMEOUT_W'(tmo);
        bus.serial_ready = 1'b1; bus.fifo_okay = fifo_en;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.busy) begin seen_busy = 1'b1; r_busy_cyc++; end
            if (bus.transfer_complete) r_tc++;
            if (bus.strobe_out && !prev_strobe) begin
                if (r_strobes < 8) r_left[r_strobes] = int'(bus.blocks_left);
                r_strobes++;
            end
            if (bus.ack_out && !prev_ack) r_acks++;
            prev_strobe = bus.strobe_out;
            prev_ack    = bus.ack_out;
            bus.block_done = bus.strobe_out;
            bus.crc_ok     = (r_strobes > nfail);
            bus.abort      = abort_on_done && bus.strobe_out;
            bus.ack_in     = ack_en && bus.ack_out;
            if (seen_busy && !bus.busy) begin ended = 1'b1; break; end
        end
        if (expect_end) check({tag, "_ended"}, 32'(ended), 32'd1);
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_code", 32'(bus.error_code), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single read, block_count ignored when multiple=0
        run_xfer(1'b0, 1'b0, 5, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 50, "single");
        check("single_strobes", 32'(r_strobes), 32'd1);
        check("single_left",    32'(r_left[0]), 32'd1);
        check("single_acks",    32'(r_acks), 32'd1);
        check("single_tc",      32'(r_tc), 32'd1);
        check("single_busy",    32'(r_busy_cyc), 32'd5);
        check("single_error",   32'(bus.error), 32'd0);

        // Multi write of three blocks
        run_xfer(1'b1, 1'b1, 3, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 60, "multi");
        check("multi_strobes", 32'(r_strobes), 32'd3);
        check("multi_acks",    32'(r_acks), 32'd3);
        check("multi_left0",   32'(r_left[0]), 32'd3);
        check("multi_left1",   32'(r_left[1]), 32'd2);
        check("multi_left2",   32'(r_left[2]), 32'd1);
        check("multi_leftend", 32'(bus.blocks_left), 32'd0);
        check("multi_tc",      32'(r_tc), 32'd1);
        check("multi_busy",    32'(r_busy_cyc), 32'd11);

        // Two CRC failures recovered by retry
        run_xfer(1'b1, 1'b0, 1, 0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 60, "retry_ok");
        check("retry_ok_strobes", 32'(r_strobes), 32'd3);
        check("retry_ok_acks",    32'(r_acks), 32'd1);
        check("retry_ok_tc",      32'(r_tc), 32'd1);
        check("retry_ok_busy",    32'(r_busy_cyc), 32'd9);
        check("retry_ok_error",   32'(bus.error), 32'd0);

        // Three CRC failures exhaust the retries
        run_xfer(1'b0, 1'b0, 1, 0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 60, "retry_bad");
        check("retry_bad_strobes", 32'(r_strobes), 32'd3);
        check("retry_bad_tc",      32'(r_tc), 32'd0);
        check("retry_bad_error",   32'(bus.error), 32'd1);
        check("retry_bad_code",    32'(bus.error_code), 32'd2);

        // Watchdog of 4 with the FIFO never ready
        run_xfer(1'b0, 1'b0, 1, 4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 40, "timeout");
        check("timeout_busy", 32'(r_busy_cyc), 32'd6);
        check("timeout_code", 32'(bus.error_code), 32'd1);
        check("timeout_tc",   32'(r_tc), 32'd0);

        // Abort coinciding with a good block_done
        run_xfer(1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 40, "abort");
        check("abort_acks", 32'(r_acks), 32'd0);
        check("abort_code", 32'(bus.error_code), 32'd3);
        check("abort_tc",   32'(r_tc), 32'd0);

        // Watchdog disabled: waits indefinitely, then abort clears it
        run_xfer(1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 60, "nowd");
        check("nowd_busy",  32'(bus.busy), 32'd1);
        check("nowd_error", 32'(bus.error), 32'd0);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        @(negedge clock);
        check("nowd_abort_code", 32'(bus.error_code), 32'd3);
        check("nowd_abort_busy", 32'(bus.busy), 32'd0);

        // Reset while waiting in ACK, then a clean transfer
        run_xfer(1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 10, "midack");
        check("midack_ack_out", 32'(bus.ack_out), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midack_rst_ack",  32'(bus.ack_out), 32'd0);
        check("midack_rst_busy", 32'(bus.busy), 32'd0);
        check("midack_rst_left", 32'(bus.blocks_left), 32'd0);
        check("midack_rst_wr",   32'(bus.write_read_phys), 32'd0);
        run_xfer(1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 50, "after_rst");
        check("after_rst_tc",   32'(r_tc), 32'd1);
        check("after_rst_acks", 32'(r_acks), 32'd2);

        // Randomized traffic, checked only by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset           = ($urandom_range(0, 249) == 0);
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.write_read  = 1'($urandom);
            bus.multiple    = 1'($urandom);
            bus.block_count = BLKCNT_W'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0:       bus.timeout_val = '0;
                1:       bus.timeout_val = TIMEOUT_W'($urandom_range(1, 3));
                default: bus.timeout_val = TIMEOUT_W'($urandom_range(4, 12));
            endcase
            bus.abort        = ($urandom_range(0, 63) == 0);
            bus.serial_ready = 1'($urandom);
            bus.fifo_okay    = ($urandom_range(0, 9) < 7);
            bus.block_done   = bus.strobe_out ? 1'($urandom) : ($urandom_range(0, 19) == 0);
            bus.crc_ok       = ($urandom_range(0, 3) != 0);
            bus.ack_in       = 1'($urandom);
        end
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
